input_ctrl: RTL
===============

INPUT_CTRL -- requirements
Module: input_ctrl

Interface
REQ-001 The module SHALL have the following parameters, one per line: name, default, meaning.
- DEB_CYCLES, 500000, number of consecutive stable cycles before a debounced input changes.
- MOVE_TICK, 1250000, number of cycles in one movement period.
- FIRE_COOLDOWN, 3125000, number of cycles after a fire during which further fires are blocked.
- X_INIT, 62, ship x1 coordinate at reset.
- Y_INIT, 452, ship y1 coordinate at reset.
- X_MIN, 12, lower clamp for x.
- X_MAX, 615, upper clamp for x.
- Y_MIN, 6, lower clamp for y.
- Y_MAX, 455, upper clamp for y.
REQ-002 The module SHALL have the following ports, one per line: name, direction, width, meaning.
- iCLK, in, 1, the single clock.
- iRST_N, in, 1, asynchronous active-low reset.
- iKey, in, 4, raw buttons, active-low: [0]=right, [1]=left, [2]=down, [3]=up.
- iShoot, in, 1, raw shoot button, active-high.
- oShip_X, out, 11, ship hull x1.
- oShip_Y, out, 11, ship hull y1.
- oMove_Tick, out, 1, one-cycle pulse at the end of each movement period.
- oKey_Db, out, 4, debounced key states, active-high (1 = pressed).
- oShoot_Db, out, 1, debounced shoot state.
- oFire, out, 1, one-cycle fire pulse.
- oFire_X, out, 11, snapshot of the ship x position, valid while oFire is high.
- oFire_Y, out, 11, snapshot of the ship y position, valid while oFire is high.
REQ-003 Clocking and reset: one clock domain (iCLK); reset is asynchronous and active-low (iRST_N).

Function
REQ-004 Every raw input SHALL pass through a 2-flop synchronizer before any other logic sees it.
REQ-005 Each of the 5 inputs SHALL have its own debounce counter.
- Counter clears whenever the synced value equals the debounced value.
- Otherwise the counter increments; on reaching DEB_CYCLES-1, the debounced value takes the synced value and the counter clears.
REQ-006 Any glitch shorter than DEB_CYCLES cycles SHALL NOT change the debounced output.
- Latency from a raw edge to the debounced edge = 2 + DEB_CYCLES cycles.
REQ-007 The tick counter SHALL run 0..MOVE_TICK-1 freely, wrap to 0, and assert oMove_Tick for exactly the cycle in which it equals MOVE_TICK-1.
REQ-008 On a tick, the module SHALL update position from the debounced keys:
- x += right − left
- y += down − up
REQ-009 Opposing keys pressed together SHALL cause a net change of 0 on that axis.
REQ-010 Position updates SHALL saturate to [X_MIN, X_MAX] and [Y_MIN, Y_MAX]:
- Never wrap.
- Never leave the range.
- Use signed-safe compare; no underflow below 0.
REQ-011 Position SHALL change only on tick cycles; a key held between ticks SHALL have no effect until the next tick.
REQ-012 A fire event is the debounced shoot falling edge (release), matching the press-then-release firing convention.
REQ-013 When a fire event occurs and the cooldown counter is 0, the module SHALL:
- Assert oFire for exactly 1 cycle, in the cycle after the falling edge is detected.
- Drive oFire_X/oFire_Y with the ship position registered in the cycle of detection, i.e. the pre-update value if a tick coincides.
- Load the cooldown counter with FIRE_COOLDOWN.
REQ-014 Release events while the cooldown counter is nonzero SHALL be dropped, not queued.
- The cooldown counter decrements to 0 and saturates there.
REQ-015 oFire_X/oFire_Y SHALL hold their last captured values while oFire is low.
REQ-016 Holding shoot continuously SHALL never generate oFire; only a release does.
REQ-017 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-018 While iRST_N=0, all outputs and state SHALL be forced asynchronously to reset values:
- oShip_X=X_INIT, oShip_Y=Y_INIT.
- oMove_Tick=0, oFire=0, oFire_X=0, oFire_Y=0.
- oKey_Db=0, oShoot_Db=0.
- All counters and synchronizers = 0, meaning released.
REQ-019 Reset asserted mid-debounce, mid-tick or during cooldown SHALL abandon the operation with no pulse emitted.
- The first tick after release occurs MOVE_TICK cycles after reset deassertion.
REQ-020 Release of reset SHALL be taken synchronously at the next iCLK edge.

Verification
Directed scenarios for the bench; MOVE_TICK/DEB_CYCLES/FIRE_COOLDOWN scaled down where noted.

REQ-021 (DEB_CYCLES=8)
- Stimulus: iKey[0] low for 5 cycles.
- Required response: oKey_Db stays 0.
- Stimulus: iKey[0] then held low.
- Required response: oKey_Db[0]=1 exactly 10 cycles after the edge.

REQ-022 (MOVE_TICK=16)
- Stimulus: right held for 3 ticks.
- Required response: oShip_X goes 62→63→64→65, changing only in tick cycles.
- Stimulus: right+left held.
- Required response: X unchanged.

REQ-023 Clamp
- Stimulus: left held from X=13 for 4 ticks.
- Required response: X goes 12,12,12,12.
- Stimulus: down held from Y=454.
- Required response: Y goes 455, then stays 455.

REQ-024 (FIRE_COOLDOWN=20)
- Stimulus: press/release shoot.
- Required response: one oFire pulse with oFire_X=62, oFire_Y=452.
- Stimulus: a second release 10 cycles later.
- Required response: no pulse.
- Stimulus: a third release after 25 cycles.
- Required response: one pulse.

REQ-025 Tick/release coincidence
- Stimulus: release detected in the same cycle as a tick moving X 70→71.
- Required response: oFire_X=70, and oShip_X=71.

REQ-026 Reset mid-cooldown with right held
- Stimulus: assert iRST_N=0 asynchronously between clock edges.
- Required response: outputs reset immediately; after release, a fire is allowed at once and the first move occurs at cycle MOVE_TICK.

Source files
------------

// File: rtl/input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : input_ctrl
// Description : Button front end for the ship controller. Synchronises and
//               debounces four direction keys and a shoot button, moves the
//               ship one pixel per movement period with clamping, and turns a
//               debounced shoot release into a one-cycle fire pulse that
//               carries a position snapshot and is rate-limited by a cooldown.
// Ports       : iCLK        - clock
//               iRST_N      - asynchronous active-low reset
//               iKey[3:0]   - raw keys, active-low: 0=right 1=left 2=down 3=up
//               iShoot      - raw shoot button, active-high
//               oShip_X/Y   - ship hull x1/y1
//               oMove_Tick  - one-cycle pulse ending each movement period
//               oKey_Db     - debounced keys, 1 = pressed
//               oShoot_Db   - debounced shoot
//               oFire       - one-cycle fire pulse
//               oFire_X/Y   - ship position captured for the fire pulse
// Revision    : 1.0 - initial release
// ============================================================================
module input_ctrl #(
  parameter int DEB_CYCLES    = 500000,
  parameter int MOVE_TICK     = 1250000,
  parameter int FIRE_COOLDOWN = 3125000,
  parameter int X_INIT        = 62,
  parameter int Y_INIT        = 452,
  parameter int X_MIN         = 12,
  parameter int X_MAX         = 615,
  parameter int Y_MIN         = 6,
  parameter int Y_MAX         = 455
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [3:0]  iKey,
  input  logic        iShoot,
  output logic [10:0] oShip_X,
  output logic [10:0] oShip_Y,
  output logic        oMove_Tick,
  output logic [3:0]  oKey_Db,
  output logic        oShoot_Db,
  output logic        oFire,
  output logic [10:0] oFire_X,
  output logic [10:0] oFire_Y
);

  localparam int c_debW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int c_tickW = (MOVE_TICK > 1) ? $clog2(MOVE_TICK) : 1;
  localparam int c_coolW = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;

  localparam logic [c_debW-1:0]  c_debLast  = c_debW'(DEB_CYCLES - 1);
  localparam logic [c_tickW-1:0] c_tickLast = c_tickW'(MOVE_TICK - 1);
  localparam logic [c_coolW-1:0] c_coolInit = c_coolW'(FIRE_COOLDOWN);

  // 12-bit signed bounds so a decrement below zero compares as negative
  localparam logic signed [11:0] c_xMin  = 12'(X_MIN);
  localparam logic signed [11:0] c_xMax  = 12'(X_MAX);
  localparam logic signed [11:0] c_yMin  = 12'(Y_MIN);
  localparam logic signed [11:0] c_yMax  = 12'(Y_MAX);
  localparam logic [10:0]        c_xInit = 11'(X_INIT);
  localparam logic [10:0]        c_yInit = 11'(Y_INIT);

  // Keys are inverted ahead of the synchronizer so that every stage holds
  // 1 = pressed and a cleared register means released.
  logic [4:0] w_raw;
  logic [4:0] r_sync1;
  logic [4:0] r_sync2;
  logic [4:0] w_db;

  assign w_raw = {iShoot, ~iKey};

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // One debouncer per input: the state follows the synced value only after
  // it has disagreed for DEB_CYCLES consecutive cycles.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_deb
      logic [c_debW-1:0] r_cnt;
      logic              r_state;

      always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
          r_cnt   <= '0;
          r_state <= 1'b0;
        end else if (r_sync2[gi] == r_state) begin
          r_cnt <= '0;
        end else if (r_cnt == c_debLast) begin
          r_state <= r_sync2[gi];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_db[gi] = r_state;
    end
  endgenerate

  // Free-running period counter; the pulse register is loaded from the next
  // count so it is high exactly while the counter sits on its last value.
  logic [c_tickW-1:0] r_tickCnt;
  logic [c_tickW-1:0] w_tickNext;
  logic               r_moveTick;

  always_comb begin
    w_tickNext = (r_tickCnt == c_tickLast) ? '0 : r_tickCnt + 1'b1;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_tickCnt  <= '0;
      r_moveTick <= 1'b0;
    end else begin
      r_tickCnt  <= w_tickNext;
      r_moveTick <= (w_tickNext == c_tickLast);
    end
  end

  // Position: opposing keys cancel, result saturates at the bounds.
  logic [10:0]        r_shipX;
  logic [10:0]        r_shipY;
  logic signed [11:0] w_xSum;
  logic signed [11:0] w_ySum;
  logic [10:0]        w_xNext;
  logic [10:0]        w_yNext;

  always_comb begin
    w_xSum = $signed({1'b0, r_shipX}) + $signed({11'd0, w_db[0]})
           - $signed({11'd0, w_db[1]});
    w_ySum = $signed({1'b0, r_shipY}) + $signed({11'd0, w_db[2]})
           - $signed({11'd0, w_db[3]});

    if (w_xSum < c_xMin)      w_xNext = c_xMin[10:0];
    else if (w_xSum > c_xMax) w_xNext = c_xMax[10:0];
    else                      w_xNext = w_xSum[10:0];

    if (w_ySum < c_yMin)      w_yNext = c_yMin[10:0];
    else if (w_ySum > c_yMax) w_yNext = c_yMax[10:0];
    else                      w_yNext = w_ySum[10:0];
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_shipX <= c_xInit;
      r_shipY <= c_yInit;
    end else if (r_moveTick) begin
      r_shipX <= w_xNext;
      r_shipY <= w_yNext;
    end
  end

  // Fire on debounced shoot release. The snapshot takes the registered
  // position of the detection cycle, so a coincident move is not included.
  logic               r_shootPrev;
  logic               w_release;
  logic [c_coolW-1:0] r_cool;
  logic               r_fire;
  logic [10:0]        r_fireX;
  logic [10:0]        r_fireY;

  assign w_release = r_shootPrev & ~w_db[4];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_shootPrev <= 1'b0;
      r_cool      <= '0;
      r_fire      <= 1'b0;
      r_fireX     <= '0;
      r_fireY     <= '0;
    end else begin
      r_shootPrev <= w_db[4];
      r_fire      <= 1'b0;
      if (w_release && (r_cool == '0)) begin
        r_fire  <= 1'b1;
        r_fireX <= r_shipX;
        r_fireY <= r_shipY;
        r_cool  <= c_coolInit;
      end else if (r_cool != '0) begin
        r_cool <= r_cool - 1'b1;
      end
    end
  end

  assign oShip_X    = r_shipX;
  assign oShip_Y    = r_shipY;
  assign oMove_Tick = r_moveTick;
  assign oKey_Db    = w_db[3:0];
  assign oShoot_Db  = w_db[4];
  assign oFire      = r_fire;
  assign oFire_X    = r_fireX;
  assign oFire_Y    = r_fireY;

endmodule
`default_nettype wire
